// File: rtl/rr_pkg.sv
// Shared constants and helpers for the weighted round-robin arbiter.
// Holds mode encodings, default geometry and a constant clog2.
package rr_pkg;

  localparam logic RR_PLAIN    = 1'b0;
  localparam logic RR_WEIGHTED = 1'b1;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_DATA_W   = 10;
  localparam int DEF_WEIGHT_W = 3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority encoder: first set req bit at start, start+1, ... mod NUM_CH.
// Latency: combinational; backpressure: none (pure function of its inputs).
module rr_priority_pick #(
  parameter int NUM_CH = 4,
  parameter int ID_W   = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ID_W-1:0]   start,
  output logic              any,
  output logic [ID_W-1:0]   idx
);

  int              c;
  logic [ID_W-1:0] cand;

  // Walk farthest-to-nearest so the last hit is the one closest to start.
  always_comb begin
    any  = |req;
    idx  = '0;
    c    = 0;
    cand = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      c = int'(start) + k;
      if (c >= NUM_CH) c = c - NUM_CH;
      cand = ID_W'(c);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/rr_arbiter_wrr.sv
// Weighted round-robin drain of NUM_CH FWFT FIFOs into one stream; pop is same-cycle,
// data_out/pop_id/valid one cycle later. Backpressure: out_full blocks the grant, turn held.
module rr_arbiter_wrr
  import rr_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ID_W     = clog2(NUM_CH),
  parameter int WEIGHT_W = DEF_WEIGHT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          empty,
  input  logic [NUM_CH*DATA_W-1:0]   fifo_data,
  input  logic [NUM_CH*WEIGHT_W-1:0] weight,
  input  logic                       mode,
  input  logic                       out_full,
  output logic [NUM_CH-1:0]          pop,
  output logic [DATA_W-1:0]          data_out,
  output logic                       valid,
  output logic [ID_W-1:0]            pop_id
);

  logic [ID_W-1:0]     cur;
  logic [WEIGHT_W-1:0] credit;
  logic                first;
  logic                stay;
  logic                any;
  logic                grant_ok;
  logic [ID_W-1:0]     start;
  logic [ID_W-1:0]     pick_idx;
  logic [ID_W-1:0]     g;
  logic [WEIGHT_W-1:0] w_sel;
  logic [WEIGHT_W-1:0] eff_w;
  logic [DATA_W-1:0]   data_sel;

  assign stay = (credit != '0) && !empty[cur];

  // Until the first grant after reset the search starts at channel 0 rather than cur+1.
  always_comb begin
    if (first || cur == ID_W'(NUM_CH - 1)) start = '0;
    else                                  start = cur + ID_W'(1);
  end

  rr_priority_pick #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_pick (
    .req   (~empty),
    .start (start),
    .any   (any),
    .idx   (pick_idx)
  );

  assign grant_ok = !reset && !out_full && any;
  assign g        = stay ? cur : pick_idx;

  always_comb begin
    pop      = '0;
    data_sel = '0;
    w_sel    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (g == ID_W'(i)) begin
        pop[i]   = grant_ok;
        data_sel = fifo_data[i*DATA_W +: DATA_W];
        w_sel    = weight[i*WEIGHT_W +: WEIGHT_W];
      end
    end
  end

  assign eff_w = (mode == RR_WEIGHTED && w_sel != '0) ? w_sel : WEIGHT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      cur      <= '0;
      credit   <= '0;
      first    <= 1'b1;
      valid    <= 1'b0;
      data_out <= '0;
      pop_id   <= '0;
    end else if (grant_ok) begin
      first    <= 1'b0;
      valid    <= 1'b1;
      data_out <= data_sel;
      pop_id   <= g;
      if (stay) begin
        credit <= credit - WEIGHT_W'(1);
      end else begin
        cur    <= g;
        credit <= eff_w - WEIGHT_W'(1);
      end
    end else begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_wrr.sv
// Bench for rr_arbiter_wrr: turn-based reference model checked every cycle,
// directed scenarios with literal grant sequences, then randomized traffic.
module tb_rr_arbiter_wrr;

  localparam int NUM_CH   = 4;
  localparam int DATA_W   = 10;
  localparam int ID_W     = 2;
  localparam int WEIGHT_W = 3;
  localparam int DV       = NUM_CH * DATA_W;
  localparam int WV       = NUM_CH * WEIGHT_W;

  logic                clk = 1'b0;
  logic                reset;
  logic [NUM_CH-1:0]   empty;
  logic [DV-1:0]       fifo_data;
  logic [WV-1:0]       weight;
  logic                mode;
  logic                out_full;
  logic [NUM_CH-1:0]   pop;
  logic [DATA_W-1:0]   data_out;
  logic                valid;
  logic [ID_W-1:0]     pop_id;

  rr_arbiter_wrr #(
    .NUM_CH   (NUM_CH),
    .DATA_W   (DATA_W),
    .ID_W     (ID_W),
    .WEIGHT_W (WEIGHT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .empty     (empty),
    .fifo_data (fifo_data),
    .weight    (weight),
    .mode      (mode),
    .out_full  (out_full),
    .pop       (pop),
    .data_out  (data_out),
    .valid     (valid),
    .pop_id    (pop_id)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit armed = 1'b0;
  int glog[$];

  // Reference state: owner of the running turn (-1 = none yet) and grants still owed.
  int                owner = -1;
  int                left  = 0;
  logic              m_valid = 1'b0;
  logic [DATA_W-1:0] m_data  = '0;
  int                m_id    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic check_seq(input string nm, input int exp[$]);
    chk({nm, " length"}, 64'(glog.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < glog.size(); i++)
      chk(nm, 64'(glog[i]), 64'(exp[i]));
  endtask

  function automatic int eff(input int ch);
    int w;
    w = int'(weight[ch*WEIGHT_W +: WEIGHT_W]);
    if (mode == 1'b0 || w == 0) return 1;
    return w;
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      bit gnt;
      int g;
      logic [NUM_CH-1:0] epop;
      gnt  = !reset && !out_full && (empty != '1);
      epop = '0;
      g    = -1;
      if (gnt) begin
        if (owner >= 0 && left > 0 && !empty[owner]) begin
          g = owner;
          left--;
        end else begin
          for (int k = 1; k <= NUM_CH; k++)
            if (g < 0 && !empty[(owner + k) % NUM_CH]) g = (owner + k) % NUM_CH;
          owner = g;
          left  = eff(g) - 1;
        end
        epop[g] = 1'b1;
        glog.push_back(g);
      end
      chk("pop", 64'(pop), 64'(epop));
      chk("valid", 64'(valid), 64'(m_valid));
      chk("pop_id", 64'(pop_id), 64'(m_id));
      chk("data_out", 64'(data_out), 64'(m_data));
      if (reset) begin
        m_valid = 1'b0; m_data = '0; m_id = 0; owner = -1; left = 0;
      end else if (gnt) begin
        m_valid = 1'b1; m_data = fifo_data[g*DATA_W +: DATA_W]; m_id = g;
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    glog.delete();
  endtask

  initial begin
    reset = 1'b1; empty = '0; weight = '0; mode = 1'b0; out_full = 1'b0;
    for (int i = 0; i < NUM_CH; i++) fifo_data[i*DATA_W +: DATA_W] = DATA_W'(16 * i + 5);
    @(posedge clk);
    #1 armed = 1'b1;
    cycles(3);
    reset = 1'b0;
    glog.delete();

    // plain round-robin from reset
    cycles(6);
    check_seq("plain_rr", '{0, 1, 2, 3, 0, 1});

    // weighted: w3..w0 = 0,2,1,3
    mode = 1'b1;
    weight = {3'd0, 3'd2, 3'd1, 3'd3};
    do_reset();
    cycles(10);
    check_seq("weighted_rr", '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0});

    // all empty, then two alternating channels
    empty = 4'b1111;
    cycles(2);
    mode = 1'b0;
    empty = 4'b1010;
    do_reset();
    cycles(4);
    check_seq("alt_0_2", '{0, 2, 0, 2});

    // channel 0 empties mid-turn and forfeits its credit
    mode = 1'b1;
    weight = {3'd1, 3'd1, 3'd1, 3'd3};
    do_reset();
    cycles(1);
    empty = 4'b1011;
    cycles(1);
    check_seq("forfeit", '{0, 2});

    // out_full holds the running turn
    empty = 4'b0000;
    do_reset();
    cycles(1);
    out_full = 1'b1;
    cycles(3);
    out_full = 1'b0;
    cycles(3);
    check_seq("out_full_hold", '{0, 0, 0, 1});

    // reset pulse mid-operation restarts at channel 0
    mode = 1'b0;
    do_reset();
    cycles(3);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    cycles(1);
    check_seq("reset_mid", '{0, 1, 2, 0});

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      empty    = NUM_CH'($urandom & $urandom);
      out_full = ($urandom_range(0, 3) == 0);
      reset    = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NUM_CH; i++) fifo_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
      if ($urandom_range(0, 7) == 0) weight = WV'($urandom);
      if ($urandom_range(0, 31) == 0) mode = ~mode;
      cycles(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
